// File: rtl/hash_rf_pkg.sv
// Shared types and constants for the FP register-file hash agent.
//   hash_rf_state_t : operation sequencer states
//   HASH_RF_REGS    : registers in the hash view of the FP file
//   HASH_RF_W       : width of the packed register view (32 bits per register)
//   reg_slice()     : extract 32-bit register i from a packed view
package hash_rf_pkg;

  localparam int HASH_RF_REGS = 32;
  localparam int HASH_RF_W    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } hash_rf_state_t;

  // Register i occupies bits [32i+31:32i] of the packed view.
  function automatic logic [31:0] reg_slice(input logic [HASH_RF_W-1:0] vec,
                                            input int unsigned          i);
    return vec[i*32 +: 32];
  endfunction

endpackage

// File: rtl/hash_rf_agent.sv
// Accelerator-side agent for the FP register-file hash port.
//
// Snapshots the 1024-bit FP register view, hands it to a hash core over a
// valid/ready handshake, captures the 1024-bit result and writes it back to
// the register file in NB = NUM_REGS/BEAT_REGS beats. A pipeline FP write that
// lands inside the current beat's masked registers wins: the whole beat is
// suppressed for that cycle and retried on the next one.
//
// Ports
//   clock, reset          : clock; synchronous active-high reset
//   start, reg_mask       : begin an operation (IDLE only); write-back mask
//   busy, done            : not-IDLE status; one-cycle completion pulse
//   rdata_hash_i_vector   : register-file read view (reg i = bits [32i+31:32i])
//   wdata_hash_o_vector   : write-back data, same packing (result register)
//   we_hash_o             : per-register write enables
//   pipe_we/fpu/rd_addr   : snooped pipeline register-file write
//   core_valid_o/ready_i/data_o : operand handshake to the hash core
//   core_valid_i/ready_o/data_i : result handshake from the hash core
module hash_rf_agent
  import hash_rf_pkg::*;
#(
  parameter int NUM_REGS  = HASH_RF_REGS,  // fixed at 32 (1024-bit view)
  parameter int BEAT_REGS = 8              // must divide NUM_REGS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [HASH_RF_REGS-1:0] reg_mask,
  output logic                    busy,
  output logic                    done,
  input  logic [HASH_RF_W-1:0]    rdata_hash_i_vector,
  output logic [HASH_RF_W-1:0]    wdata_hash_o_vector,
  output logic [HASH_RF_REGS-1:0] we_hash_o,
  input  logic                    pipe_we,
  input  logic                    pipe_fpu,
  input  logic [4:0]              pipe_rd_addr,
  output logic                    core_valid_o,
  input  logic                    core_ready_i,
  output logic [HASH_RF_W-1:0]    core_data_o,
  input  logic                    core_valid_i,
  output logic                    core_ready_o,
  input  logic [HASH_RF_W-1:0]    core_data_i
);

  localparam int NB        = NUM_REGS / BEAT_REGS;
  localparam int BEAT_W    = (NB > 1) ? $clog2(NB) : 1;
  localparam int REG_SHIFT = $clog2(BEAT_REGS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NB - 1);

  hash_rf_state_t            state_q,  state_d;
  logic [HASH_RF_REGS-1:0]   mask_q,   mask_d;
  logic [HASH_RF_W-1:0]      snap_q,   snap_d;
  logic [HASH_RF_W-1:0]      result_q, result_d;
  logic [BEAT_W-1:0]         beat_q,   beat_d;

  // Registers belonging to the beat currently being written.
  logic [HASH_RF_REGS-1:0]   beat_sel;
  logic [4:0]                rd_beat;
  logic                      rd_in_beat;
  logic                      conflict;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_beat_sel
    assign beat_sel[gi] = (BEAT_W'(gi / BEAT_REGS) == beat_q);
  end

  // The pipeline destination falls in the current beat when its upper
  // address bits equal the beat index.
  assign rd_beat    = pipe_rd_addr >> REG_SHIFT;
  assign rd_in_beat = (rd_beat == 5'(beat_q));
  // Only a collision on a register we would actually write stalls the beat.
  assign conflict   = pipe_we && pipe_fpu && rd_in_beat && mask_q[pipe_rd_addr];

  assign core_data_o         = snap_q;
  assign wdata_hash_o_vector = result_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      snap_q   <= '0;
      result_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      snap_q   <= snap_d;
      result_q <= result_d;
      beat_q   <= beat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    snap_d       = snap_q;
    result_d     = result_q;
    beat_d       = beat_q;
    busy         = 1'b1;
    done         = 1'b0;
    core_valid_o = 1'b0;
    core_ready_o = 1'b0;
    we_hash_o    = '0;

    unique case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          mask_d  = reg_mask;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        snap_d  = rdata_hash_i_vector;
        state_d = ST_ISSUE;
      end

      // Operand held stable (snap_q) until the core takes it.
      ST_ISSUE: begin
        core_valid_o = 1'b1;
        if (core_ready_i) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        core_ready_o = 1'b1;
        if (core_valid_i) begin
          result_d = core_data_i;
          beat_d   = '0;
          state_d  = ST_WRITE;
        end
      end

      // A beat with an empty mask slice still consumes its cycle.
      ST_WRITE: begin
        if (!conflict) begin
          we_hash_o = mask_q & beat_sel;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hash_rf_agent.sv
module tb_hash_rf_agent;
  import hash_rf_pkg::*;

  localparam int W = HASH_RF_W;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   reg_mask;
  logic          busy, done;
  logic [W-1:0]  rdata_hash_i_vector;
  logic [W-1:0]  wdata_hash_o_vector;
  logic [31:0]   we_hash_o;
  logic          pipe_we, pipe_fpu;
  logic [4:0]    pipe_rd_addr;
  logic          core_valid_o, core_ready_i;
  logic [W-1:0]  core_data_o;
  logic          core_valid_i, core_ready_o;
  logic [W-1:0]  core_data_i;

  always #5 clock = ~clock;

  hash_rf_agent #(.NUM_REGS(32), .BEAT_REGS(8)) dut (
    .clock(clock), .reset(reset), .start(start), .reg_mask(reg_mask),
    .busy(busy), .done(done),
    .rdata_hash_i_vector(rdata_hash_i_vector),
    .wdata_hash_o_vector(wdata_hash_o_vector),
    .we_hash_o(we_hash_o),
    .pipe_we(pipe_we), .pipe_fpu(pipe_fpu), .pipe_rd_addr(pipe_rd_addr),
    .core_valid_o(core_valid_o), .core_ready_i(core_ready_i), .core_data_o(core_data_o),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o), .core_data_i(core_data_i)
  );

  int errors = 0;
  int checks = 0;

  // Register-file model: preload pattern or hash write-back.
  logic [31:0] rf [32];
  logic        preload;
  always @(posedge clock) begin
    for (int i = 0; i < 32; i++) begin
      if (preload) rf[i] <= 32'h1000_0000 + 32'(i);
      else if (we_hash_o[i]) rf[i] <= wdata_hash_o_vector[i*32 +: 32];
    end
  end
  always_comb begin
    rdata_hash_i_vector = '0;
    for (int i = 0; i < 32; i++) rdata_hash_i_vector[i*32 +: 32] = rf[i];
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 32; i++) begin
        if (reg_slice(act, i) !== reg_slice(exp, i)) begin
          $display("FAIL %s: reg %0d got %h expected %h", name, i,
                   reg_slice(act, i), reg_slice(exp, i));
          break;
        end
      end
    end
  endtask

  // Hand-derived register-file images.
  function automatic logic [W-1:0] vec_p();
    logic [W-1:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    return v;
  endfunction

  function automatic logic [W-1:0] sel(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [31:0] pick);
    logic [W-1:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = pick[i] ? a[i*32 +: 32] : b[i*32 +: 32];
    return v;
  endfunction

  logic [W-1:0] P, N, S2, M;

  // Scoreboard queues.
  logic [W-1:0] exp_op [$];
  logic [31:0]  exp_we [$];

  task automatic push_we_full();
    exp_we.push_back(32'h0000_00FF);
    exp_we.push_back(32'h0000_FF00);
    exp_we.push_back(32'h00FF_0000);
    exp_we.push_back(32'hFF00_0000);
  endtask

  // Mock hash core: result = operand XOR all-ones, 2 idle cycles after accept.
  int           stall_cnt = 0;
  int           cst, lat;
  logic [W-1:0] op;
  initial begin
    core_ready_i = 1'b0;
    core_valid_i = 1'b0;
    core_data_i  = '0;
    cst = 0;
    lat = 0;
    forever begin
      @(posedge clock); #1;
      case (cst)
        0: begin
          if (core_valid_o) begin
            if (stall_cnt > 0) begin
              core_ready_i = 1'b0;
              stall_cnt--;
            end else begin
              core_ready_i = 1'b1;
              op  = core_data_o;
              lat = 2;
              cst = 1;
            end
          end else begin
            core_ready_i = 1'b0;
          end
        end
        1: begin
          core_ready_i = 1'b0;
          if (lat > 0) lat--;
          else begin
            core_valid_i = 1'b1;
            core_data_i  = ~op;
            cst = core_ready_o ? 3 : 2;
          end
        end
        2: if (core_ready_o) cst = 3;
        default: begin
          core_valid_i = 1'b0;
          cst = 0;
        end
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  bit in_wb = 0;
  int issue_len = 0;
  int last_issue_len = 0;
  initial begin
    forever begin
      @(negedge clock);
      if (core_valid_o) begin
        issue_len++;
        if (exp_op.size() == 0) begin
          errors++; checks++;
          $display("FAIL operand_unexpected: got valid with no expected operand");
        end else begin
          chkw("operand", core_data_o, exp_op[0]);
          if (core_ready_i) begin
            void'(exp_op.pop_front());
            last_issue_len = issue_len;
            issue_len = 0;
          end
        end
      end
      if (in_wb) begin
        if (exp_we.size() > 0) chk32("we_beat", we_hash_o, exp_we.pop_front());
        else begin
          chk32("done_pulse", {31'b0, done}, 32'd1);
          in_wb = 0;
        end
      end else begin
        if (done) chk32("done_spurious", {31'b0, done}, 32'd0);
        if (we_hash_o != 32'd0) chk32("we_spurious", we_hash_o, 32'd0);
      end
      if (core_valid_i && core_ready_o) in_wb = 1;
      if (reset) begin
        in_wb = 0;
        issue_len = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] mask);
    @(posedge clock); #1;
    start = 1'b1;
    reg_mask = mask;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (done) begin got = 1; break; end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if (core_valid_i && core_ready_o) begin got = 1; break; end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL accept_timeout: got no result handshake expected one within 300 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    P  = vec_p();
    N  = ~P;
    S2 = sel(P, N, 32'h0000_0005);
    M  = sel(S2, ~S2, 32'h0000_FFFF);

    reset = 1'b1; preload = 1'b1; start = 1'b0; reg_mask = '0;
    pipe_we = 1'b0; pipe_fpu = 1'b0; pipe_rd_addr = '0;
    repeat (3) @(posedge clock);
    #1;
    preload = 1'b0;
    chk32("rst_busy",    {31'b0, busy}, 32'd0);
    chk32("rst_done",    {31'b0, done}, 32'd0);
    chk32("rst_cvalid",  {31'b0, core_valid_o}, 32'd0);
    chk32("rst_cready",  {31'b0, core_ready_o}, 32'd0);
    chk32("rst_we",      we_hash_o, 32'd0);
    chkw ("rst_wdata",   wdata_hash_o_vector, '0);
    reset = 1'b0;

    // Basic, full mask.
    exp_op.push_back(P); push_we_full();
    issue(32'hFFFF_FFFF);
    wait_done();
    chk32("basic_issue_len", 32'(last_issue_len), 32'd1);
    chk32("basic_rf3", rf[3], 32'hEFFF_FFFC);

    // Back-to-back, partial mask; snapshot sees the first op's write-back.
    exp_op.push_back(N);
    exp_we.push_back(32'h5); exp_we.push_back(32'h0);
    exp_we.push_back(32'h0); exp_we.push_back(32'h0);
    issue(32'h0000_0005);
    wait_done();
    chk32("partial_rf0", rf[0], 32'h1000_0000);
    chk32("partial_rf1", rf[1], 32'hEFFF_FFFE);
    chk32("partial_rf2", rf[2], 32'h1000_0002);
    chk32("partial_rf5", rf[5], 32'hEFFF_FFFA);

    // FP pipeline write into beat 1 stalls it for one cycle.
    exp_op.push_back(S2);
    exp_we.push_back(32'h0000_00FF); exp_we.push_back(32'h0);
    exp_we.push_back(32'h0000_FF00); exp_we.push_back(32'h00FF_0000);
    exp_we.push_back(32'hFF00_0000);
    issue(32'hFFFF_FFFF);
    wait_accept();
    @(posedge clock); #1;
    @(posedge clock); #1;
    pipe_we = 1'b1; pipe_fpu = 1'b1; pipe_rd_addr = 5'd9;
    @(posedge clock); #1;
    pipe_we = 1'b0; pipe_fpu = 1'b0;
    wait_done();
    chk32("conflict_rf9", rf[9], 32'h1000_0009);
    chk32("conflict_rf0", rf[0], 32'hEFFF_FFFF);

    // Same collision on the integer file: no stall.
    exp_op.push_back(~S2); push_we_full();
    issue(32'hFFFF_FFFF);
    wait_accept();
    @(posedge clock); #1;
    @(posedge clock); #1;
    pipe_we = 1'b1; pipe_fpu = 1'b0; pipe_rd_addr = 5'd9;
    @(posedge clock); #1;
    pipe_we = 1'b0;
    wait_done();
    chk32("nofpu_rf9", rf[9], 32'hEFFF_FFF6);

    // Backpressure: ready low 5 cycles, stray starts ignored.
    exp_op.push_back(S2); push_we_full();
    stall_cnt = 5;
    issue(32'hFFFF_FFFF);
    repeat (2) begin
      @(posedge clock); #1; start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
    end
    wait_done();
    chk32("bp_issue_len", 32'(last_issue_len), 32'd6);
    chk32("bp_rf4", rf[4], 32'h1000_0004);

    // Reset during WRITE after beat 1.
    exp_op.push_back(~S2);
    exp_we.push_back(32'h0000_00FF); exp_we.push_back(32'h0000_FF00);
    issue(32'hFFFF_FFFF);
    wait_accept();
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk32("abort_busy",  {31'b0, busy}, 32'd0);
    chk32("abort_we",    we_hash_o, 32'd0);
    chk32("abort_done",  {31'b0, done}, 32'd0);
    chkw ("abort_wdata", wdata_hash_o_vector, '0);
    reset = 1'b0;
    chk32("abort_rf3",  rf[3],  32'hEFFF_FFFC);
    chk32("abort_rf20", rf[20], 32'h1000_0014);

    // Fresh operation after the abort completes normally.
    exp_op.push_back(M); push_we_full();
    issue(32'hFFFF_FFFF);
    wait_done();
    chk32("after_rf3",  rf[3],  32'h1000_0003);
    chk32("after_rf20", rf[20], 32'hEFFF_FFEB);

    repeat (3) @(posedge clock);
    #1;
    chk32("queues_empty", 32'(exp_op.size() + exp_we.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
